// File: rtl/clk_div_multi_if.sv
// Control/status bundle for clk_div_multi.
//   master : drives en, load, load_ch, load_val; observes clkout, tick, pend.
//   slave  : the divider side of the same signals.
interface clk_div_multi_if #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned NCH   = 4,
  parameter int unsigned CH_W  = 2
);
  logic [NCH-1:0]   en;
  logic             load;
  logic [CH_W-1:0]  load_ch;
  logic [CNT_W-1:0] load_val;
  logic [NCH-1:0]   clkout;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   pend;

  modport master (
    output en, load, load_ch, load_val,
    input  clkout, tick, pend
  );

  modport slave (
    input  en, load, load_ch, load_val,
    output clkout, tick, pend
  );
endinterface

// File: rtl/clk_div_multi.sv
// Multi-channel 50%-duty clock divider with per-channel tick pulse and
// run-time programmable divisor.
//   clkin : system clock, all state on its rising edge
//   rst   : synchronous, active-high reset
//   bus   : clk_div_multi_if.slave
//           en[NCH]        per-channel run enable
//           load/load_ch/load_val  write a pending divisor into one channel
//           clkout[NCH]    divided clock, half period = div+1 cycles
//           tick[NCH]      one-cycle pulse after each terminal count
//           pend[NCH]      a loaded divisor is waiting to be applied
module clk_div_multi #(
  parameter int unsigned    CNT_W       = 32,
  parameter int unsigned    NCH         = 4,
  parameter int unsigned    CH_W        = 2,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(25000000)
) (
  input  logic             clkin,
  input  logic             rst,
  clk_div_multi_if.slave   bus
);

  logic [CNT_W-1:0] cnt_q      [NCH];
  logic [CNT_W-1:0] cnt_d      [NCH];
  logic [CNT_W-1:0] div_q      [NCH];
  logic [CNT_W-1:0] div_d      [NCH];
  logic [CNT_W-1:0] pend_val_q [NCH];
  logic [CNT_W-1:0] pend_val_d [NCH];
  logic [NCH-1:0]   clkout_q, clkout_d;
  logic [NCH-1:0]   tick_q,   tick_d;
  logic [NCH-1:0]   pend_q,   pend_d;

  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      cnt_d[i]      = cnt_q[i];
      div_d[i]      = div_q[i];
      pend_val_d[i] = pend_val_q[i];
      clkout_d[i]   = clkout_q[i];
      tick_d[i]     = 1'b0;
      pend_d[i]     = pend_q[i];

      if (bus.en[i]) begin
        // Comparing for equality (never counting past div) means the full
        // counter range is usable and there is no wrap-around path.
        if (cnt_q[i] == div_q[i]) begin
          cnt_d[i]    = '0;
          clkout_d[i] = ~clkout_q[i];
          tick_d[i]   = 1'b1;
          // Swapping the divisor only at the toggle keeps every half
          // period whole: the new value governs the next half period.
          if (pend_q[i]) begin
            div_d[i]  = pend_val_q[i];
            pend_d[i] = 1'b0;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else if (pend_q[i]) begin
        // Idle channel: apply the pending divisor at once and restart.
        div_d[i]  = pend_val_q[i];
        cnt_d[i]  = '0;
        pend_d[i] = 1'b0;
      end

      // A load lands after any apply above, so a load coinciding with an
      // apply stays pending for the following terminal count.
      if (bus.load && (bus.load_ch == CH_W'(i))) begin
        pend_val_d[i] = bus.load_val;
        pend_d[i]     = 1'b1;
      end
    end
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt_q[i]      <= '0;
        div_q[i]      <= DEFAULT_DIV;
        pend_val_q[i] <= '0;
      end
      clkout_q <= '0;
      tick_q   <= '0;
      pend_q   <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt_q[i]      <= cnt_d[i];
        div_q[i]      <= div_d[i];
        pend_val_q[i] <= pend_val_d[i];
      end
      clkout_q <= clkout_d;
      tick_q   <= tick_d;
      pend_q   <= pend_d;
    end
  end

  assign bus.clkout = clkout_q;
  assign bus.tick   = tick_q;
  assign bus.pend   = pend_q;

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Parametrised, multi-channel successor to the team's fixed single-output clock divider.
- Each of NCH channels produces a 50%-duty divided clock and a one-cycle tick pulse from the board clock.
- Each channel has its own run-time programmable divisor, with glitch-free reload at the terminal count.
- Feeds display refresh, debounce and game-timing logic from one shared clock domain.

Parameters:
- CNT_W, 32, width of per-channel counter and divisor.
- NCH, 4, number of independent channels.
- CH_W, 2, width of channel-select field; NCH <= 2**CH_W.
- DEFAULT_DIV, 25000000, divisor loaded into every channel at reset.

Ports:
- clkin  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  NCH  per-channel run enable.
- load  input  1  one-cycle strobe: write load_val as pending divisor of channel load_ch.
- load_ch  input  CH_W  target channel for load.
- load_val  input  CNT_W  new divisor value.
- clkout  output  NCH  divided clock per channel, registered.
- tick  output  NCH  one-cycle pulse per channel at terminal count, registered.
- pend  output  NCH  high while a loaded divisor is waiting to take effect.

Behaviour:
- Reset (rst=1 at a clkin edge), every channel:
  - cnt=0, div=DEFAULT_DIV, pend_val=0.
  - clkout=0, tick=0, pend=0.
  - rst has priority over load and en.
- Per channel, en=1:
  - If cnt==div (terminal count): cnt<=0, clkout<=~clkout, tick<=1.
  - Otherwise: cnt<=cnt+1, tick<=0.
  - Half period is div+1 cycles; clkout period is 2*(div+1).
  - Tick period is div+1; tick is high in the cycle after the edge where cnt==div.
- div=0: clkout toggles every cycle; tick is constantly 1.
- en=0:
  - cnt and clkout hold; tick<=0.
  - If pend=1: div<=pend_val, cnt<=0, pend<=0 in that cycle.
- Load, with load=1 and load_ch<NCH:
  - pend_val[load_ch]<=load_val; pend[load_ch]<=1.
  - load_ch>=NCH: load is ignored.
- Reload while running:
  - At a terminal count with pend=1: div<=pend_val, pend<=0.
  - The new divisor governs the very next half period; no runt pulse, no missed toggle.
- Load in the same cycle as a terminal count of that channel:
  - Any previously pending value is applied at this terminal count.
  - The new load_val becomes pending and is applied at the following terminal count. pend stays 1.
- Second load while pend=1: overwrites pend_val (last write wins); only the final value is applied.
- Counter never exceeds div; no arithmetic wrap-around path exists. Divisor 2**CNT_W-1 is legal.
- en deasserted mid-count then reasserted: counting resumes from the held cnt with no extra toggle.
- Channels are fully independent; a load targets exactly one channel.
- Outputs depend only on registers; no combinational path from inputs to outputs.

Test Plan:
- Bench override DEFAULT_DIV=3, NCH=4.
  - Release rst with en=4'b1111 -> clkout[0] rises 4 cycles after release and toggles every 4 cycles.
  - tick pulses every 4 cycles aligned with each toggle; pend=0.
- Hold rst high for 10 cycles with en=1 -> all outputs stay 0.
  - Assert rst mid-count (cnt=2) -> next cycle cnt=0, clkout=0, tick=0, div back to 3.
- Load ch1 with div=1 at cnt=1 -> pend[1]=1 until the terminal count.
  - The current half period still lasts 4 cycles; half periods thereafter last 2 cycles.
  - Channels 0, 2 and 3 are unaffected.
- Load ch2 with 5, then 7 two cycles later, both before the terminal count -> only 7 is applied.
  - Half period becomes 8 cycles; pend[2] clears at that terminal count.
- Load ch0 with 0 exactly on its terminal-count cycle (old pend=0) -> the 4-cycle half period continues once more, then toggles every cycle.
  - tick[0] stays high continuously after that.
- en[3]=0 with a pending load of 2, then en[3]=1 -> div applied and cnt=0 while disabled; clkout and tick held/0.
  - After re-enable, first toggle occurs after 3 cycles.
  - load_ch=3 with NCH=3 override -> ignored.
